// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA raster timing generator with a divide-by-4 pixel enable.
// Sync and blanking flops are loaded from the next counter values, so they line up with hcount/vcount.
module vga_sync_ctrl #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       clr,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_tick,
    output logic       frame_tick
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    logic [1:0] ps;
    logic       h_last, v_last;
    logic [9:0] h_nxt, v_nxt;
    assign pix_en = &ps;
    always_comb begin
        h_last = hcount == 10'(H_TOT - 1);
        v_last = vcount == 10'(V_TOT - 1);
        h_nxt  = pix_en ? (h_last ? '0 : hcount + 10'd1) : hcount;
        v_nxt  = (pix_en && h_last) ? (v_last ? '0 : vcount + 10'd1) : vcount;
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ps         <= '0;
            hcount     <= '0;
            vcount     <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b1;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            ps         <= ps + 2'd1;
            hcount     <= h_nxt;
            vcount     <= v_nxt;
            hsync      <= !(h_nxt >= 10'(H_VIS + H_FP) && h_nxt < 10'(H_VIS + H_FP + H_SYNC));
            vsync      <= !(v_nxt >= 10'(V_VIS + V_FP) && v_nxt < 10'(V_VIS + V_FP + V_SYNC));
            video_on   <= h_nxt < 10'(H_VIS) && v_nxt < 10'(V_VIS);
            line_tick  <= pix_en && h_last;
            frame_tick <= pix_en && h_last && v_last;
        end
    end
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: checks a default-size and a shrunken timing generator every cycle
// against an arithmetic raster model, with random asynchronous resets mid-frame.
module tb_vga_sync_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic       pe_a, hs_a, vs_a, vo_a, lt_a, ft_a;
    logic [9:0] h_a, v_a;
    logic       pe_b, hs_b, vs_b, vo_b, lt_b, ft_b;
    logic [9:0] h_b, v_b;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vga_sync_ctrl dut_a (
        .clk(clk), .clr(clr), .pix_en(pe_a), .hcount(h_a), .vcount(v_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .line_tick(lt_a), .frame_tick(ft_a)
    );

    vga_sync_ctrl #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .clr(clr), .pix_en(pe_b), .hcount(h_b), .vcount(v_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .line_tick(lt_b), .frame_tick(ft_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // k = rising edges since reset release; k < 0 means reset is asserted
    task automatic model(input int k, input int hv, input int hf, input int hsy, input int hb,
                         input int vv, input int vf, input int vsy, input int vb,
                         output int pe, output int h, output int v, output int hs,
                         output int vs, output int vo, output int lt, output int ft);
        int ht, vt, t;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        if (k < 0) begin
            pe = 0; h = 0; v = 0; hs = 1; vs = 1; vo = 1; lt = 0; ft = 0;
        end else begin
            t  = (k / 4) % (ht * vt);
            h  = t % ht;
            v  = t / ht;
            pe = int'(k % 4 == 3);
            hs = int'(!(h >= hv + hf && h < hv + hf + hsy));
            vs = int'(!(v >= vv + vf && v < vv + vf + vsy));
            vo = int'(h < hv && v < vv);
            lt = int'(k >= 4 && k % 4 == 0 && h == 0);
            ft = int'(lt == 1 && v == 0);
        end
    endtask

    task automatic check_one(input string nm, input int k,
                             input int hv, input int hf, input int hsy, input int hb,
                             input int vv, input int vf, input int vsy, input int vb,
                             input logic pe, input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic vo,
                             input logic lt, input logic ft);
        int epe, eh, ev, ehs, evs, evo, elt, eft;
        model(k, hv, hf, hsy, hb, vv, vf, vsy, vb, epe, eh, ev, ehs, evs, evo, elt, eft);
        chk({nm, ".pix_en"}, {31'd0, pe}, epe);
        chk({nm, ".hcount"}, {22'd0, h}, eh);
        chk({nm, ".vcount"}, {22'd0, v}, ev);
        chk({nm, ".hsync"}, {31'd0, hs}, ehs);
        chk({nm, ".vsync"}, {31'd0, vs}, evs);
        chk({nm, ".video_on"}, {31'd0, vo}, evo);
        chk({nm, ".line_tick"}, {31'd0, lt}, elt);
        chk({nm, ".frame_tick"}, {31'd0, ft}, eft);
    endtask

    task automatic check_all(input int k);
        check_one("dflt", k, 640, 16, 96, 48, 480, 10, 2, 33,
                  pe_a, h_a, v_a, hs_a, vs_a, vo_a, lt_a, ft_a);
        check_one("small", k, 8, 2, 3, 2, 4, 1, 2, 1,
                  pe_b, h_b, v_b, hs_b, vs_b, vo_b, lt_b, ft_b);
    endtask

    initial begin
        int k, len, last_ft, last_lt;
        repeat (3) @(negedge clk);
        check_all(-1);
        clr = 1'b0;
        k = 0;
        last_ft = -1;
        last_lt = -1;
        // one long uninterrupted run: several small frames and two full default lines
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            k++;
            check_all(k);
            if (ft_b) begin
                if (last_ft >= 0) chk("small.frame_period", k - last_ft, 480);
                last_ft = k;
            end
            if (lt_a) begin
                if (last_lt >= 0) chk("dflt.line_period", k - last_lt, 3200);
                last_lt = k;
            end
        end
        // random asynchronous resets landing between clock edges
        for (int s = 0; s < 16; s++) begin
            #($urandom_range(1, 3));
            clr = 1'b1;
            #1 check_all(-1);
            len = $urandom_range(1, 3);
            repeat (len) begin
                @(negedge clk);
                check_all(-1);
            end
            clr = 1'b0;
            k = 0;
            len = $urandom_range(8, 900);
            repeat (len) begin
                @(negedge clk);
                k++;
                check_all(k);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
